// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction prefetch queue owning the fetch PC and ROM address
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic [PC_W-1:0]            rom_addr,
    input  logic [INSTR_W-1:0]         rom_instr,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INSTR_W-1:0]         deq_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]      count_q,    count_d;
    logic [PC_W-1:0]    entry_pc_q    [DEPTH];
    logic [INSTR_W-1:0] entry_instr_q [DEPTH];

    logic deq;
    logic enq;

    always_comb begin
        deq        = (count_q != '0) & deq_ready;
        // A full queue still accepts a fetch when its head leaves this cycle.
        enq        = !redirect & ((count_q < C_DEPTH) | deq);
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + PC_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entries are cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc_q[i]    <= '0;
                entry_instr_q[i] <= '0;
            end
        end else if (enq) begin
            entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
            entry_instr_q[wr_ptr_q] <= rom_instr;
        end
    end

    assign rom_addr  = fetch_pc_q;
    assign deq_valid = (count_q != '0);
    assign deq_pc    = entry_pc_q[rd_ptr_q];
    assign deq_instr = entry_instr_q[rd_ptr_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : randomized self-checking bench for fetch_queue
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    logic                clk;
    logic                rst;
    logic                redirect;
    logic [PC_W-1:0]     redirect_pc;
    logic [PC_W-1:0]     rom_addr;
    logic [INSTR_W-1:0]  rom_instr;
    logic                deq_ready;
    logic                deq_valid;
    logic [PC_W-1:0]     deq_pc;
    logic [INSTR_W-1:0]  deq_instr;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of fetched pairs plus the fetch PC.
    int unsigned m_pc[$];
    int unsigned m_ins[$];
    int unsigned m_fpc;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .rom_addr   (rom_addr),
        .rom_instr  (rom_instr),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .deq_pc     (deq_pc),
        .deq_instr  (deq_instr),
        .count      (count)
    );

    function automatic int unsigned rom(input int unsigned a);
        return 32'h1000_0000 + (a & 32'hFF);
    endfunction

    assign rom_instr = rom(32'(rom_addr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc.delete();
        m_ins.delete();
        m_fpc = 0;
    endtask

    // Compare every visible output against the model.
    task automatic compare();
        chk("rom_addr", rom_addr, m_fpc);
        chk("count", count, m_pc.size());
        chk("deq_valid", deq_valid, m_pc.size() != 0);
        if (m_pc.size() != 0) begin
            chk("deq_pc", deq_pc, m_pc[0]);
            chk("deq_instr", deq_instr, m_ins[0]);
        end
    endtask

    // Advance model with current inputs, clock once, then compare.
    task automatic step();
        bit d;
        d = (m_pc.size() != 0) && deq_ready;
        if (redirect) begin
            m_pc.delete();
            m_ins.delete();
            m_fpc = redirect_pc;
        end else begin
            if (d) begin
                void'(m_pc.pop_front());
                void'(m_ins.pop_front());
            end
            if (m_pc.size() < DEPTH) begin
                m_pc.push_back(m_fpc);
                m_ins.push_back(rom(m_fpc));
                m_fpc = (m_fpc + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_valid", deq_valid, 0);
        chk("rst_pc", deq_pc, 0);
        chk("rst_instr", deq_instr, 0);
        chk("rst_count", count, 0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        deq_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming: one instruction per cycle, occupancy stays 1.
        deq_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stream_pc", deq_pc, k);
            chk("stream_instr", deq_instr, 32'h1000_0000 + k);
            chk("stream_count", count, 1);
        end

        // Fill from reset with the consumer stalled.
        deq_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("fill_count", count, (k < 4) ? k : 4);
        end
        chk("fill_rom_addr", rom_addr, 4);
        chk("fill_head", deq_pc, 0);

        // Drain a full queue with simultaneous enqueue: contiguous pcs.
        deq_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("full_pc", deq_pc, k);
            chk("full_count", count, 4);
        end

        // Redirect while three entries are held.
        deq_ready = 1'b0;
        do_reset();
        repeat (3) step();
        chk("pre_redir_count", count, 3);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        chk("redir_count", count, 0);
        chk("redir_valid", deq_valid, 0);
        chk("redir_rom_addr", rom_addr, 8'h40);
        redirect = 1'b0;
        step();
        chk("redir_head_pc", deq_pc, 8'h40);
        chk("redir_head_instr", deq_instr, 32'h1000_0040);

        // PC wrap through 0xFF with pointers wrapping too.
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect = 1'b0;
        deq_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("wrap_pc", deq_pc, (8'hFE + k) % 256);
        end

        // Asynchronous reset between edges with two entries held.
        deq_ready = 1'b0;
        do_reset();
        repeat (2) step();
        chk("pre_async_count", count, 2);
        #2;
        do_reset();
        step();
        chk("post_async_pc", deq_pc, 0);
        chk("post_async_count", count, 1);

        // Randomized traffic including back-to-back redirects and resets.
        for (int n = 0; n < 3000; n++) begin
            deq_ready   = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = PC_W'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) begin
                redirect = 1'b0;
                do_reset();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Prefetch queue between the instruction ROM and the fetch/decode pipeline register. It owns the fetch PC, drives the ROM address, and buffers up to DEPTH fetched {pc, instr} pairs. It presents the oldest pair to the decode side with a valid/ready handshake. A redirect from the branch/jump resolution in the memory stage flushes the queue and restarts fetch at the target PC.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- PC_W, 8: program-counter width (word address).
- INSTR_W, 32: instruction width.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
- redirect  input  1  taken branch or jump; flush and refetch.
- redirect_pc  input  PC_W  target PC, sampled when redirect=1.
- rom_addr  output  PC_W  ROM address; equals the fetch_pc register.
- rom_instr  input  INSTR_W  combinational ROM data for rom_addr.
- deq_ready  input  1  consumer accepts the head this cycle (not stalled).
- deq_valid  output  1  head entry present; equals (count != 0).
- deq_pc  output  PC_W  PC of head entry.
- deq_instr  output  INSTR_W  instruction of head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- State: fetch_pc, wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, and an entry array of {pc, instr}.
- deq = deq_valid & deq_ready.
- enq = !redirect & (count < DEPTH | deq).
  - When the queue is full, enqueue is allowed in the same cycle as a dequeue.
- On enq:
  - entry[wr_ptr] <= {fetch_pc, rom_instr}.
  - wr_ptr++.
  - fetch_pc <= fetch_pc + 1, wrapping modulo 2^PC_W (255 -> 0 at default width).
- On deq: rd_ptr++.
- count update: count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- When count=DEPTH and deq=0, there is no enqueue and fetch_pc holds.
- Redirect has priority over every other event:
  - count, wr_ptr and rd_ptr go to 0.
  - fetch_pc <= redirect_pc.
  - A dequeue in the same cycle still counts as accepted by the consumer, but the queue is emptied regardless.
  - The rom_instr of that cycle is discarded.
- deq_pc and deq_instr come combinationally from entry[rd_ptr].
  - When deq_valid=0 their value is don't-care for consumers.
  - They must be 0 after reset.

## Timing
- Reset (rst=0), asynchronous:
  - fetch_pc, pointers and count go to 0.
  - All entries are cleared to 0.
  - Resulting outputs: rom_addr=0, deq_valid=0, deq_pc=0, deq_instr=0, count=0.
- Reset asserted mid-operation discards all entries and the fetch PC without waiting for a clock edge.
- First clock edge after rst deasserts: entry 0 is loaded with {0, ROM[0]}. deq_valid=1 from that edge on.
- Fetch-to-head latency: 1 cycle when the queue is empty.
- Sustained throughput: 1 instruction per cycle when deq_ready=1 continuously. The queue then stays at count=1.
- Redirect at edge N:
  - After N: deq_valid=0 and rom_addr=redirect_pc.
  - After N+1: head = {redirect_pc, ROM[redirect_pc]}.
  - This gives a 1-cycle bubble.
- Back-to-back redirects: each one restarts fetch. Only the last target is ever enqueued.
- deq_ready=0 while full: queue contents, fetch_pc and outputs are frozen.

## Test plan
- Reset, then deq_ready=1 for 6 cycles with ROM[i]=0x1000_0000+i:
  - Required: deq_pc sequence 0,1,2,3,4,5 with matching instrs.
  - Required: count stays 1 after the first edge.
- deq_ready=0 from reset:
  - Required: count goes 1,2,3,4 then holds 4.
  - Required: rom_addr holds 4.
  - Required: raising deq_ready then delivers pc 0..3 followed by 4 with no gap.
- Full queue with deq_ready=1:
  - Required: simultaneous enq/deq keeps count=4.
  - Required: pc stream remains contiguous.
- redirect=1, redirect_pc=0x40 while count=3:
  - Required: next cycle count=0, deq_valid=0, rom_addr=0x40.
  - Required: the cycle after, head pc=0x40, instr=ROM[0x40].
- Redirect to 0xFE, deq_ready=1:
  - Required: dequeued pcs 0xFE, 0xFF, 0x00, 0x01 (PC wrap).
  - Required: pointer wrap after 4+ enqueues is correct.
- rst pulsed low between clock edges while count=2:
  - Required: outputs go to 0 immediately, without waiting for an edge.
  - Required: after release, fetch restarts at pc 0.
